bus_src_sel: RTL
================

# bus_src_sel

Parametrised, registered successor to the datapath's 8:1 register-select multiplexer. It selects one of NSRC WIDTH-bit sources and presents it on a registered output with a valid/ready handshake. A scan mode streams every source in index order, for debug dumps of MAX/MIN/R0/COUNT/SUM/PC/IR/TEMP-style registers. It sits between the ASIP register bank and the result/debug bus.

## Interface
- WIDTH, 8, bit width of each source and of the output.
- NSRC, 8, number of sources (2..64); need not be a power of two.
- SELW, $clog2(NSRC), selector width (derived; do not override).
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- src_flat  input  NSRC*WIDTH  source k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SELW  source index for a single read.
- req  input  1  single-read request, sampled at the clock edge.
- scan_start  input  1  start a full scan of sources 0..NSRC-1.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  WIDTH  registered selected data.
- out_src  output  SELW  index of the source in out_data.
- out_valid  output  1  out_data/out_src valid.
- sel_err  output  1  current beat came from an out-of-range sel.
- busy  output  1  scan in progress.
- scan_done  output  1  one-cycle pulse after the last scan beat is accepted.

## Operation
- States: IDLE, SCAN. Output register slot is "free" when !out_valid, or when out_valid && out_ready (handshake this edge).
- Reset: state IDLE; out_data=0, out_src=0, out_valid=0, sel_err=0, busy=0, scan_done=0, scan index=0.
- IDLE, slot free, scan_start=1: go to SCAN, busy=1, load src 0 (out_src=0, out_valid=1).
- IDLE, slot free, req=1, scan_start=0: load src[sel], out_src=sel, out_valid=1. If sel>=NSRC: out_data=0, sel_err=1 for that beat.
- scan_start and req in the same cycle: scan wins, and req is dropped.
- IDLE, slot not free: req and scan_start are ignored, with no queuing. The requester retries.
- Slot free, no new load: out_valid clears. sel_err clears with it.
- While out_valid && !out_ready: out_data, out_src and sel_err hold stable, and sources are not re-sampled.
- SCAN: on each handshake, load the next index. Data is sampled at load time, not at start. When handshake of index NSRC-1 completes: go to IDLE, busy=0, scan_done=1 for one cycle, out_valid=0.
- In SCAN, req and scan_start are ignored. A new request is only accepted in the cycle after scan_done.
- Asynchronous reset mid-beat or mid-scan aborts immediately to reset values. No scan_done is generated.

## Timing
- Single read latency is 1 cycle: req at edge n gives out_valid high after edge n.
- Back-to-back single reads run at 1 per cycle when out_ready stays high. A req in a cycle with a completing handshake loads on the same edge.
- A full scan takes a minimum of NSRC cycles from the scan_start edge to the last handshake. scan_done is asserted in the cycle after the last handshake.
- Outputs are fully registered, so there is no combinational path from any input to any output.

## Configuration
- BUS_SRC_SEL_PARITY_EN defined:
  - out_data widens to WIDTH+1. The MSB is even parity (XOR) of the selected WIDTH bits, computed at load time.
  - The parity bit is 0 for sel_err beats and 0 at reset.
- BUS_SRC_SEL_PARITY_EN undefined: out_data is WIDTH bits and carries no parity logic.

## Test plan
- Reset check: assert rst_n=0 mid-scan with out_valid=1 -> all outputs 0 immediately (asynchronously), with no scan_done pulse. After release, IDLE.
- Single read: WIDTH=8, NSRC=8, src k = 8'h10+k, sel=3, req one cycle, out_ready=1 -> next cycle out_data=8'h13, out_src=3, out_valid=1, then out_valid=0.
- Backpressure: req sel=5 with out_ready=0 for 4 cycles -> out_data=8'h15 held 4 cycles. Req sel=2 during the stall is ignored. Accepted on out_ready=1.
- Scan: scan_start with out_ready toggling 1,0,1,... -> beats 8'h10..8'h17 in order, each held while stalled. busy high throughout. scan_done pulses once after the 8th accept.
- Priority and error: with NSRC=6, raise scan_start and req (sel=1) together -> scan runs, and no sel=1 beat is emitted. Later req sel=7 -> out_data=0, sel_err=1, out_src=7.
- Parity (with macro): source value 8'h07 selected -> out_data=9'h107. Source value 8'h03 selected -> out_data=9'h003.

Source files
------------

// File: rtl/bus_src_sel.sv
// Registered NSRC:1 source selector with valid/ready output and an index-order scan mode.
// Build macro BUS_SRC_SEL_PARITY_EN widens out_data by one even-parity MSB.
module bus_src_sel #(
  parameter int WIDTH = 8,
  parameter int NSRC  = 8,
  parameter int SELW  = $clog2(NSRC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NSRC*WIDTH-1:0] src_flat,
  input  logic [SELW-1:0]       sel,
  input  logic                  req,
  input  logic                  scan_start,
  input  logic                  out_ready,
`ifdef BUS_SRC_SEL_PARITY_EN
  output logic [WIDTH:0]        out_data,
`else
  output logic [WIDTH-1:0]      out_data,
`endif
  output logic [SELW-1:0]       out_src,
  output logic                  out_valid,
  output logic                  sel_err,
  output logic                  busy,
  output logic                  scan_done
);

`ifdef BUS_SRC_SEL_PARITY_EN
  localparam int OW = WIDTH + 1;
`else
  localparam int OW = WIDTH;
`endif
  localparam logic [SELW-1:0] LAST = SELW'(NSRC - 1);

  typedef enum logic {ST_IDLE, ST_SCAN} state_t;

  // Returns {hit, data}; hit is 0 and data is 0 when idx is not a real source.
  function automatic logic [WIDTH:0] pick(input logic [NSRC*WIDTH-1:0] flat,
                                          input logic [SELW-1:0]       idx);
    logic [WIDTH:0] res;
    res = {(WIDTH+1){1'b0}};
    for (int k = 0; k < NSRC; k++) begin
      res = (idx == SELW'(k)) ? {1'b1, flat[k*WIDTH +: WIDTH]} : res;
    end
    return res;
  endfunction

  function automatic logic [OW-1:0] encode(input logic [WIDTH-1:0] d);
`ifdef BUS_SRC_SEL_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  state_t          r_state;
  logic [OW-1:0]   r_data;
  logic [SELW-1:0] r_src;
  logic            r_valid;
  logic            r_err;
  logic            r_busy;
  logic            r_done;

  logic            w_slot_free;
  logic            w_handshake;
  logic [SELW-1:0] w_nxt_idx;
  logic [WIDTH:0]  w_pick_sel;
  logic [WIDTH:0]  w_pick_nxt;
  logic [OW-1:0]   w_src0;

  // Slot availability and the two candidate source values for this edge.
  always_comb begin
    w_slot_free = !r_valid || out_ready;
    w_handshake = r_valid && out_ready;
    w_nxt_idx   = r_src + SELW'(1);
    w_pick_sel  = pick(src_flat, sel);
    w_pick_nxt  = pick(src_flat, w_nxt_idx);
    w_src0      = encode(src_flat[WIDTH-1:0]);
  end

  // Control FSM; every output is a register written here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_data  <= {OW{1'b0}};
      r_src   <= {SELW{1'b0}};
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_slot_free) begin
            if (scan_start) begin
              r_state <= ST_SCAN;
              r_busy  <= 1'b1;
              r_data  <= w_src0;
              r_src   <= {SELW{1'b0}};
              r_valid <= 1'b1;
              r_err   <= 1'b0;
            end else if (req) begin
              // An out-of-range sel yields zero data (and zero parity).
              r_data  <= encode(w_pick_sel[WIDTH-1:0]);
              r_src   <= sel;
              r_valid <= 1'b1;
              r_err   <= !w_pick_sel[WIDTH];
            end else begin
              r_valid <= 1'b0;
              r_err   <= 1'b0;
            end
          end
        end
        ST_SCAN: begin
          if (w_handshake) begin
            if (r_src == LAST) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_valid <= 1'b0;
              r_err   <= 1'b0;
            end else begin
              r_data <= encode(w_pick_nxt[WIDTH-1:0]);
              r_src  <= w_nxt_idx;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

  assign out_data  = r_data;
  assign out_src   = r_src;
  assign out_valid = r_valid;
  assign sel_err   = r_err;
  assign busy      = r_busy;
  assign scan_done = r_done;

endmodule
